// File: rtl/sd_spi_xfer_if.sv
// Bundle of the SD SPI engine's upstream handshake and card pins.
// The slave modport is the engine's view; the master modport is the
// sequencer/card side. Defining SD_SPI_CRC16_EN adds CrcClear/CrcOut.
interface sd_spi_xfer_if #(
    parameter int DATA_W = 8
) ();
    logic              TxValid;
    logic              TxReady;
    logic [DATA_W-1:0] TxData;
    logic              FastMode;
    logic              CsHigh;
    logic              CsHold;
    logic              RxValid;
    logic [DATA_W-1:0] RxData;
    logic              Busy;
    logic              SPI_SCLK;
    logic              SPI_MOSI;
    logic              SPI_MISO;
    logic              SPI_CS_n;
`ifdef SD_SPI_CRC16_EN
    logic              CrcClear;
    logic [15:0]       CrcOut;

    modport slave (
        input  TxValid, TxData, FastMode, CsHigh, CsHold, SPI_MISO, CrcClear,
        output TxReady, RxValid, RxData, Busy, SPI_SCLK, SPI_MOSI, SPI_CS_n, CrcOut
    );
    modport master (
        output TxValid, TxData, FastMode, CsHigh, CsHold, SPI_MISO, CrcClear,
        input  TxReady, RxValid, RxData, Busy, SPI_SCLK, SPI_MOSI, SPI_CS_n, CrcOut
    );
`else
    modport slave (
        input  TxValid, TxData, FastMode, CsHigh, CsHold, SPI_MISO,
        output TxReady, RxValid, RxData, Busy, SPI_SCLK, SPI_MOSI, SPI_CS_n
    );
    modport master (
        output TxValid, TxData, FastMode, CsHigh, CsHold, SPI_MISO,
        input  TxReady, RxValid, RxData, Busy, SPI_SCLK, SPI_MOSI, SPI_CS_n
    );
`endif
endinterface

// File: rtl/sd_spi_xfer.sv
// SPI mode-0, MSB-first transfer engine for the SD peripheral.
// One word per valid/ready handshake, slow/fast SCLK divider chosen per
// word, CS hold between words and dummy-clock words with CS high.
// Optional macro SD_SPI_CRC16_EN adds a running CRC16-CCITT over MISO.
module sd_spi_xfer #(
    parameter int DATA_W   = 8,
    parameter int DIV_W    = 8,
    parameter int SLOW_DIV = 62,
    parameter int FAST_DIV = 1
) (
    input  logic         MasterCLK,
    input  logic         Reset,
    sd_spi_xfer_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] SLOW_CNT = DIV_W'(SLOW_DIV);
    localparam logic [DIV_W-1:0] FAST_CNT = DIV_W'(FAST_DIV);

    // Refuse to elaborate configurations the counters cannot represent.
    if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
        $error("sd_spi_xfer: DATA_W must be in 2..32");
    end
    if (longint'(SLOW_DIV) >= (longint'(1) << DIV_W) ||
        longint'(FAST_DIV) >= (longint'(1) << DIV_W)) begin : g_bad_div
        $error("sd_spi_xfer: SLOW_DIV/FAST_DIV do not fit in DIV_W bits");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              div_sel_reg;
    logic              cs_skip_reg;
    logic              sclk_reg;
    logic              mosi_reg;
    logic              cs_n_reg;
    logic              rx_valid_reg;
    logic              busy_reg;
    logic [DIV_W-1:0]  div_lim;
    logic              div_hit;

    assign div_lim = div_sel_reg ? FAST_CNT : SLOW_CNT;
    assign div_hit = (div_cnt_reg == div_lim);

    // Transfer FSM; every pin and status output is a register written here.
    // The shift register takes MISO into its LSB on each rising SCLK, so its
    // MSB always holds the next MOSI bit at the following falling SCLK.
    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            rx_data_reg  <= '0;
            div_sel_reg  <= 1'b0;
            cs_skip_reg  <= 1'b0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b1;
            cs_n_reg     <= 1'b1;
            rx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cs_n_reg <= ~bus.CsHold;
                    mosi_reg <= 1'b1;
                    if (bus.TxValid) begin
                        shift_reg   <= bus.TxData;
                        div_sel_reg <= bus.FastMode;
                        cs_skip_reg <= bus.CsHigh;
                        bit_cnt_reg <= LAST_BIT;
                        mosi_reg    <= bus.TxData[DATA_W-1];
                        div_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        cs_n_reg    <= bus.CsHigh;
                        state_reg   <= LOW;
                    end
                end
                LOW: begin
                    if (div_hit) begin
                        sclk_reg    <= 1'b1;
                        shift_reg   <= {shift_reg[DATA_W-2:0], bus.SPI_MISO};
                        div_cnt_reg <= '0;
                        state_reg   <= HIGH;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                HIGH: begin
                    if (div_hit) begin
                        sclk_reg    <= 1'b0;
                        div_cnt_reg <= '0;
                        if (bit_cnt_reg != '0) begin
                            mosi_reg    <= shift_reg[DATA_W-1];
                            bit_cnt_reg <= bit_cnt_reg - CNT_W'(1);
                            state_reg   <= LOW;
                        end else begin
                            rx_data_reg  <= shift_reg;
                            rx_valid_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                            mosi_reg     <= 1'b1;
                            // Held links keep CS low through the turnaround
                            // cycle so back-to-back words see no CS glitch.
                            cs_n_reg     <= ~(bus.CsHold & ~cs_skip_reg);
                            state_reg    <= DONE;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                default: begin
                    cs_n_reg  <= ~bus.CsHold;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.TxReady  = (state_reg == IDLE);
    assign bus.RxValid  = rx_valid_reg;
    assign bus.RxData   = rx_data_reg;
    assign bus.Busy     = busy_reg;
    assign bus.SPI_SCLK = sclk_reg;
    assign bus.SPI_MOSI = mosi_reg;
    assign bus.SPI_CS_n = cs_n_reg;

`ifdef SD_SPI_CRC16_EN
    logic [15:0] crc_reg;
    logic        crc_fb;

    assign crc_fb = crc_reg[15] ^ bus.SPI_MISO;

    // CRC16-CCITT advanced on each MISO sample of a CS-asserted word.
    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            crc_reg <= 16'h0000;
        end else if (state_reg == IDLE && bus.CrcClear) begin
            crc_reg <= 16'h0000;
        end else if (state_reg == LOW && div_hit && !cs_skip_reg) begin
            crc_reg <= {crc_reg[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
        end
    end

    assign bus.CrcOut = crc_reg;
`endif
endmodule

// File: tb/tb_sd_spi_xfer.sv
// Self-checking bench for sd_spi_xfer (DATA_W=8, SLOW_DIV=62, FAST_DIV=1).
// A cycle-position model derives every pin value from the word's accept
// point; directed tests add literal latency/count/data expectations.
module tb_sd_spi_xfer;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    sd_spi_xfer_if #(.DATA_W(W)) bus ();

    sd_spi_xfer #(
        .DATA_W  (W),
        .DIV_W   (8),
        .SLOW_DIV(62),
        .FAST_DIV(1)
    ) dut (
        .MasterCLK(clk),
        .Reset    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at t=%0t", name, $time);
    endtask

    // ---------------- behavioural model / compare process ----------------
    logic [W-1:0] miso_word;
    bit           m_active = 0, m_pend = 0, m_fast, m_skip, p_fast, p_skip;
    bit           hold_prev = 0;
    int           m_k = 0;
    logic [W-1:0] m_data, m_miso, p_data, p_miso;
    int           sclk_rises = 0, rx_pulses = 0, cs_glitch = 0;
    bit           cs_watch = 0;
    logic         prev_sclk = 1'b0;

    always @(negedge clk) begin : model
        int   per, lastk, i;
        logic e_busy, e_sclk, e_mosi, e_cs, e_rxv, e_rdy;
        bit   done_now;
        if (!rst_n) begin
            m_active = 0;
            m_pend   = 0;
            hold_prev = 0;
            prev_sclk = 1'b0;
            bus.SPI_MISO = 1'b1;
            chk("rst_sclk",  32'(bus.SPI_SCLK), 32'(0));
            chk("rst_mosi",  32'(bus.SPI_MOSI), 32'(1));
            chk("rst_cs_n",  32'(bus.SPI_CS_n), 32'(1));
            chk("rst_busy",  32'(bus.Busy),     32'(0));
            chk("rst_rxv",   32'(bus.RxValid),  32'(0));
            chk("rst_rxdat", 32'(bus.RxData),   32'(0));
            chk("rst_ready", 32'(bus.TxReady),  32'(1));
        end else begin
            if (m_pend) begin
                m_active = 1;
                m_k      = 1;
                m_data   = p_data;
                m_miso   = p_miso;
                m_fast   = p_fast;
                m_skip   = p_skip;
            end else if (m_active) begin
                m_k++;
            end
            e_busy = 0; e_sclk = 0; e_mosi = 1; e_rxv = 0; e_rdy = 1;
            e_cs = !hold_prev;
            done_now = 0;
            bus.SPI_MISO = 1'b1;
            if (m_active) begin
                per   = m_fast ? 2 : 63;
                lastk = 2 * W * per;
                e_rdy = 0;
                if (m_k <= lastk) begin
                    i      = (m_k - 1) / (2 * per);
                    e_busy = 1;
                    e_sclk = (((m_k - 1) / per) % 2) != 0;
                    e_mosi = m_data[3'(W - 1 - i)];
                    e_cs   = m_skip;
                    bus.SPI_MISO = m_miso[3'(W - 1 - i)];
                end else begin
                    e_rxv    = 1;
                    e_cs     = !(hold_prev && !m_skip);
                    done_now = 1;
                    chk("rx_data", 32'(bus.RxData), 32'(m_miso));
                end
            end
            chk("busy",  32'(bus.Busy),     32'(e_busy));
            chk("sclk",  32'(bus.SPI_SCLK), 32'(e_sclk));
            chk("mosi",  32'(bus.SPI_MOSI), 32'(e_mosi));
            chk("cs_n",  32'(bus.SPI_CS_n), 32'(e_cs));
            chk("rxv",   32'(bus.RxValid),  32'(e_rxv));
            chk("ready", 32'(bus.TxReady),  32'(e_rdy));
            if (done_now) m_active = 0;
            if (bus.SPI_SCLK && !prev_sclk) sclk_rises++;
            prev_sclk = bus.SPI_SCLK;
            if (bus.RxValid) rx_pulses++;
            if (cs_watch && bus.SPI_CS_n) cs_glitch++;
            m_pend    = bus.TxValid && bus.TxReady;
            p_data    = bus.TxData;
            p_fast    = bus.FastMode;
            p_skip    = bus.CsHigh;
            p_miso    = miso_word;
            hold_prev = bus.CsHold;
        end
    end

    // ---------------- stimulus helpers ----------------
    int acc_cyc;

    task automatic start(input logic [W-1:0] d, input logic fm, input logic ch,
                         input logic [W-1:0] mw);
        int g;
        bus.TxData   = d;
        bus.FastMode = fm;
        bus.CsHigh   = ch;
        miso_word    = mw;
        bus.TxValid  = 1'b1;
        g = 0;
        @(negedge clk);
        while (!bus.TxReady && g < 100) begin
            g++;
            @(negedge clk);
        end
        if (g >= 100) timeout("accept");
        @(posedge clk);
        #1;
        bus.TxValid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_rx(output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.RxValid && g < 3000) begin
            g++;
            @(negedge clk);
        end
        if (g >= 3000) timeout("rx_valid");
        lat = cyc - acc_cyc + 1;
        $display("word tx=%h rx=%h fast=%0d cs_high=%0d latency=%0d",
                 bus.TxData, bus.RxData, bus.FastMode, bus.CsHigh, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [W-1:0] d, input logic fm, input logic ch,
                        input logic [W-1:0] mw, output int lat);
        start(d, fm, ch, mw);
        wait_rx(lat);
    endtask

    // ---------------- directed tests ----------------
    logic [W-1:0] s_words [6];
    logic [W-1:0] s_misos [6];

    initial begin
        int lat, base_r, base_v, g, idx, first, last;
        s_words = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
        s_misos = '{8'h01, 8'hFF, 8'h00, 8'hAA, 8'h55, 8'h3C};
        rst_n        = 1'b0;
        bus.TxValid  = 1'b0;
        bus.TxData   = '0;
        bus.FastMode = 1'b0;
        bus.CsHigh   = 1'b0;
        bus.CsHold   = 1'b0;
        miso_word    = '0;
`ifdef SD_SPI_CRC16_EN
        bus.CrcClear = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_ready", 32'(bus.TxReady), 32'(1));
        chk("lit_rst_cs_n",  32'(bus.SPI_CS_n), 32'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // slow word 0x40, card returns 0xA5
        base_r = sclk_rises; base_v = rx_pulses;
        xfer(8'h40, 1'b0, 1'b0, 8'hA5, lat);
        chk("slow_latency", 32'(lat), 32'(1009));
        chk("slow_rxdata",  32'(bus.RxData), 32'h0000_00A5);
        chk("slow_rises",   32'(sclk_rises - base_r), 32'(8));
        chk("slow_pulses",  32'(rx_pulses - base_v), 32'(1));

        // ten dummy-clock words with CS high while CS hold is set
        bus.CsHold = 1'b1;
        base_r = sclk_rises;
        for (int n = 0; n < 10; n++) xfer(8'hFF, 1'b1, 1'b1, 8'hFF, lat);
        chk("dummy_rises",   32'(sclk_rises - base_r), 32'(80));
        chk("dummy_latency", 32'(lat), 32'(33));

        // streamed CMD0 frame, TxValid held, CS held low
        base_v = rx_pulses;
        bus.FastMode = 1'b1;
        bus.CsHigh   = 1'b0;
        bus.TxData   = s_words[0];
        miso_word    = s_misos[0];
        bus.TxValid  = 1'b1;
        idx = 0; g = 0; first = 0;
        while (idx < 6 && g < 1000) begin
            @(negedge clk);
            g++;
            if (bus.TxValid && bus.TxReady) begin
                @(posedge clk);
                #1;
                if (idx == 0) begin
                    first = cyc;
                    cs_glitch = 0;
                    cs_watch = 1;
                end
                idx++;
                if (idx < 6) begin
                    bus.TxData = s_words[idx];
                    miso_word  = s_misos[idx];
                end else begin
                    bus.TxValid = 1'b0;
                end
            end
        end
        if (g >= 1000) timeout("stream_accept");
        g = 0;
        @(negedge clk);
        while (!bus.RxValid && g < 200) begin
            g++;
            @(negedge clk);
        end
        if (g >= 200) timeout("stream_rx");
        last = cyc;
        $display("stream of 6 words done, last rx=%h", bus.RxData);
        @(posedge clk);
        #1;
        cs_watch = 0;
        chk("stream_span",   32'(last - first + 1), 32'(203));
        chk("stream_pulses", 32'(rx_pulses - base_v), 32'(6));
        chk("stream_cs_low", 32'(cs_glitch), 32'(0));
        chk("stream_rxdata", 32'(bus.RxData), 32'h0000_003C);
        bus.CsHold = 1'b0;

        // asynchronous reset in the middle of a slow word
        base_r = sclk_rises; base_v = rx_pulses;
        start(8'h81, 1'b0, 1'b0, 8'h7E);
        g = 0;
        while (sclk_rises < base_r + 3 && g < 2000) begin
            @(posedge clk);
            g++;
        end
        if (g >= 2000) timeout("third_rise");
        #3;
        chk("pre_rst_sclk", 32'(bus.SPI_SCLK), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sclk", 32'(bus.SPI_SCLK), 32'(0));
        chk("mid_rst_mosi", 32'(bus.SPI_MOSI), 32'(1));
        chk("mid_rst_cs_n", 32'(bus.SPI_CS_n), 32'(1));
        chk("mid_rst_busy", 32'(bus.Busy), 32'(0));
        chk("mid_rst_rxv",  32'(bus.RxValid), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_no_rx", 32'(rx_pulses - base_v), 32'(0));
        xfer(8'hC3, 1'b0, 1'b0, 8'h3C, lat);
        chk("post_rst_latency", 32'(lat), 32'(1009));
        chk("post_rst_rxdata",  32'(bus.RxData), 32'h0000_003C);

        // FastMode/CsHigh/TxData changes mid-word do not disturb it
        start(8'h3C, 1'b0, 1'b0, 8'hC5);
        repeat (400) @(posedge clk);
        #1;
        bus.FastMode = 1'b1;
        bus.CsHigh   = 1'b1;
        bus.TxData   = 8'h00;
        wait_rx(lat);
        chk("toggle_slow_latency", 32'(lat), 32'(1009));
        chk("toggle_slow_rxdata",  32'(bus.RxData), 32'h0000_00C5);
        xfer(8'h95, 1'b1, 1'b0, 8'h5A, lat);
        chk("toggle_fast_latency", 32'(lat), 32'(33));
        chk("toggle_fast_rxdata",  32'(bus.RxData), 32'h0000_005A);

`ifdef SD_SPI_CRC16_EN
        bus.CrcClear = 1'b1;
        @(posedge clk);
        #1;
        bus.CrcClear = 1'b0;
        chk("crc_cleared", 32'(bus.CrcOut), 32'h0000_0000);
        for (int n = 0; n < 512; n++) xfer(8'hFF, 1'b1, 1'b0, 8'hFF, lat);
        chk("crc_512_ff", 32'(bus.CrcOut), 32'h0000_7FA1);
        bus.CrcClear = 1'b1;
        @(posedge clk);
        #1;
        bus.CrcClear = 1'b0;
        chk("crc_clear_idle", 32'(bus.CrcOut), 32'h0000_0000);
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
